// File: rtl/sprite_mover.sv
// Moves one SPRITE_W x SPRITE_H rectangle on a 160x120 framebuffer. Each move
// is an erase pass, a one-cycle update, then a draw pass, one pixel per clock.
module sprite_mover #(
  parameter int         X_SCREEN_PIXELS = 160,
  parameter int         Y_SCREEN_PIXELS = 120,
  parameter int         SPRITE_W        = 4,
  parameter int         SPRITE_H        = 4,
  parameter int         STEP            = 1,
  parameter int         START_X         = 50,
  parameter int         START_Y         = 50,
  parameter logic [2:0] SPRITE_COLOUR   = 3'b100,
  parameter logic [2:0] BG_COLOUR       = 3'b000,
  parameter int         FRAME_CYCLES    = 833333
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iForwardX,
  input  logic       iBackX,
  input  logic       iForwardY,
  input  logic       iBackY,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oDone,
  output logic [7:0] oPosX,
  output logic [6:0] oPosY
);

  localparam int         CW    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [8:0] MAX_X = 9'(X_SCREEN_PIXELS - SPRITE_W);
  localparam logic [7:0] MAX_Y = 8'(Y_SCREEN_PIXELS - SPRITE_H);

  typedef enum logic [2:0] {INIT, WAIT, ERASE, UPDATE, DRAW, DONE} state_t;

  state_t        state;
  logic [CW-1:0] tickCount;
  logic          tick;
  logic          pending;
  logic [7:0]    posX, latchX, nextX;
  logic [6:0]    posY, latchY, nextY;
  logic [4:0]    cx, cy, scanX, scanY, stepX, stepY;
  logic          scanLast, passDone;
  logic [8:0]    sumX;
  logic [7:0]    sumY;

  assign oPosX = posX;
  assign oPosY = posY;

  // WAIT and UPDATE emit the first pixel of a pass, so the scan restarts at 0.
  always_comb begin
    tick     = (tickCount == '0);
    scanX    = (state == WAIT || state == UPDATE) ? 5'd0 : cx;
    scanY    = (state == WAIT || state == UPDATE) ? 5'd0 : cy;
    scanLast = (scanX == 5'(SPRITE_W - 1)) && (scanY == 5'(SPRITE_H - 1));
    stepX    = (scanX == 5'(SPRITE_W - 1)) ? 5'd0 : scanX + 5'd1;
    stepY    = (scanX == 5'(SPRITE_W - 1)) ? scanY + 5'd1 : scanY;
    sumX     = {1'b0, posX} + 9'(STEP);
    sumY     = {1'b0, posY} + 8'(STEP);
    nextX    = posX;
    nextY    = posY;
    if (iForwardX && !iBackX)
      nextX = (sumX > MAX_X) ? MAX_X[7:0] : sumX[7:0];
    else if (iBackX && !iForwardX)
      nextX = (posX < 8'(STEP)) ? 8'd0 : posX - 8'(STEP);
    if (iForwardY && !iBackY)
      nextY = (sumY > MAX_Y) ? MAX_Y[6:0] : sumY[6:0];
    else if (iBackY && !iForwardY)
      nextY = (posY < 7'(STEP)) ? 7'd0 : posY - 7'(STEP);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state     <= INIT;
      tickCount <= CW'(FRAME_CYCLES - 1);
      pending   <= 1'b0;
      posX      <= 8'(START_X);
      posY      <= 7'(START_Y);
      latchX    <= 8'(START_X);
      latchY    <= 7'(START_Y);
      cx        <= 5'd0;
      cy        <= 5'd0;
      passDone  <= 1'b0;
      oX        <= 8'd0;
      oY        <= 7'd0;
      oColour   <= 3'd0;
      oPlot     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      tickCount <= tick ? CW'(FRAME_CYCLES - 1) : tickCount - CW'(1);
      // Ticks collapse into one flag; WAIT consumes it every cycle it sits there.
      pending   <= tick | (pending & (state != WAIT));
      oDone     <= 1'b0;
      case (state)
        INIT, DRAW: begin
          if (passDone) begin
            oPlot    <= 1'b0;
            oDone    <= 1'b1;
            passDone <= 1'b0;
            state    <= DONE;
          end else begin
            oPlot    <= 1'b1;
            oX       <= posX + 8'(scanX);
            oY       <= posY + 7'(scanY);
            oColour  <= SPRITE_COLOUR;
            cx       <= stepX;
            cy       <= stepY;
            passDone <= scanLast;
          end
        end
        WAIT: begin
          oPlot <= 1'b0;
          if (pending && (nextX != posX || nextY != posY)) begin
            latchX   <= nextX;
            latchY   <= nextY;
            oPlot    <= 1'b1;
            oX       <= posX + 8'(scanX);
            oY       <= posY + 7'(scanY);
            oColour  <= BG_COLOUR;
            cx       <= stepX;
            cy       <= stepY;
            passDone <= scanLast;
            state    <= ERASE;
          end
        end
        ERASE: begin
          if (passDone) begin
            oPlot    <= 1'b0;
            passDone <= 1'b0;
            state    <= UPDATE;
          end else begin
            oPlot    <= 1'b1;
            oX       <= posX + 8'(scanX);
            oY       <= posY + 7'(scanY);
            oColour  <= BG_COLOUR;
            cx       <= stepX;
            cy       <= stepY;
            passDone <= scanLast;
          end
        end
        UPDATE: begin
          posX     <= latchX;
          posY     <= latchY;
          oPlot    <= 1'b1;
          oX       <= latchX + 8'(scanX);
          oY       <= latchY + 7'(scanY);
          oColour  <= SPRITE_COLOUR;
          cx       <= stepX;
          cy       <= stepY;
          passDone <= scanLast;
          state    <= DRAW;
        end
        DONE:    state <= WAIT;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: three instances (defaults, right-edge clamp, fast
// frame rate) exercised in turn against a shared expected-pixel queue.
module tb_sprite_mover;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic        fwdX = 1'b0, bkX = 1'b0, fwdY = 1'b0, bkY = 1'b0;
  logic [7:0]  xs    [3];
  logic [6:0]  ys    [3];
  logic [2:0]  cs    [3];
  logic [7:0]  pxs   [3];
  logic [6:0]  pys   [3];
  logic        plots [3];
  logic        dones [3];

  logic [17:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          run_len  [3] = '{0, 0, 0};
  int          done_cnt [3] = '{0, 0, 0};
  int          cyc;

  always #5 clk = ~clk;

  sprite_mover #(.FRAME_CYCLES(20)) dut_a (
    .iClock(clk), .iReset(rst[0]), .iForwardX(fwdX), .iBackX(bkX),
    .iForwardY(fwdY), .iBackY(bkY), .oX(xs[0]), .oY(ys[0]), .oColour(cs[0]),
    .oPlot(plots[0]), .oDone(dones[0]), .oPosX(pxs[0]), .oPosY(pys[0]));

  sprite_mover #(.START_X(154), .STEP(4), .FRAME_CYCLES(20)) dut_b (
    .iClock(clk), .iReset(rst[1]), .iForwardX(fwdX), .iBackX(bkX),
    .iForwardY(fwdY), .iBackY(bkY), .oX(xs[1]), .oY(ys[1]), .oColour(cs[1]),
    .oPlot(plots[1]), .oDone(dones[1]), .oPosX(pxs[1]), .oPosY(pys[1]));

  sprite_mover #(.FRAME_CYCLES(10)) dut_c (
    .iClock(clk), .iReset(rst[2]), .iForwardX(fwdX), .iBackX(bkX),
    .iForwardY(fwdY), .iBackY(bkY), .oX(xs[2]), .oY(ys[2]), .oColour(cs[2]),
    .oPlot(plots[2]), .oDone(dones[2]), .oPosX(pxs[2]), .oPosY(pys[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_rect(input int x0, input int y0, input logic [2:0] col);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        exp_q.push_back({8'(x0 + x), 7'(y0 + y), col});
  endtask

  task automatic wait_plot(input int k, input int budget, output int c);
    c = 0;
    while (!plots[k] && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("plot_timeout", 32'(plots[k]), 32'd1);
  endtask

  task automatic wait_done(input int k, input int budget, output int c);
    c = 0;
    while (!dones[k] && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_timeout", 32'(dones[k]), 32'd1);
  endtask

  // Scoreboard: every plotted pixel pops one expected entry; each run of
  // plot-high cycles outside reset must be one whole 16-pixel pass.
  always @(negedge clk) begin
    logic [17:0] got;
    for (int k = 0; k < 3; k++) begin
      if (plots[k]) begin
        if (exp_q.size() == 0)
          check("unexpected_plot", 32'(plots[k]), 32'd0);
        else begin
          got = {xs[k], ys[k], cs[k]};
          check("pixel", 32'(got), 32'(exp_q.pop_front()));
        end
        run_len[k]++;
      end else begin
        if (run_len[k] != 0 && !rst[k])
          check("pass_length", 32'(run_len[k]), 32'd16);
        run_len[k] = 0;
      end
      if (dones[k]) done_cnt[k]++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- instance A: reset state, init draw, idle ----
    repeat (3) @(negedge clk);
    check("rst_x", 32'(xs[0]), 32'd0);
    check("rst_y", 32'(ys[0]), 32'd0);
    check("rst_colour", 32'(cs[0]), 32'd0);
    check("rst_plot", 32'(plots[0]), 32'd0);
    check("rst_done", 32'(dones[0]), 32'd0);
    check("rst_posx", 32'(pxs[0]), 32'd50);
    check("rst_posy", 32'(pys[0]), 32'd50);
    check("rst_posx_b", 32'(pxs[1]), 32'd154);
    push_rect(50, 50, 3'b100);
    rst[0] = 1'b0;
    wait_done(0, 100, cyc);
    repeat (200) @(negedge clk);
    check("idle_done_cnt", 32'(done_cnt[0]), 32'd1);
    check("idle_queue", 32'(exp_q.size()), 32'd0);

    // ---- A: one step +X, with move latency ----
    push_rect(50, 50, 3'b000);
    push_rect(51, 50, 3'b100);
    fwdX = 1'b1;
    wait_plot(0, 60, cyc);
    fwdX = 1'b0;
    wait_done(0, 100, cyc);
    check("move_latency", 32'(cyc), 32'd33);
    repeat (2) @(negedge clk);
    check("fx_posx", 32'(pxs[0]), 32'd51);
    check("fx_posy", 32'(pys[0]), 32'd50);
    check("fx_queue", 32'(exp_q.size()), 32'd0);
    check("fx_done_cnt", 32'(done_cnt[0]), 32'd2);

    // ---- A: opposing X buttons cancel, Y moves back ----
    push_rect(51, 50, 3'b000);
    push_rect(51, 49, 3'b100);
    fwdX = 1'b1; bkX = 1'b1; bkY = 1'b1;
    wait_plot(0, 60, cyc);
    fwdX = 1'b0; bkX = 1'b0; bkY = 1'b0;
    wait_done(0, 100, cyc);
    repeat (2) @(negedge clk);
    check("diag_posx", 32'(pxs[0]), 32'd51);
    check("diag_posy", 32'(pys[0]), 32'd49);
    check("diag_queue", 32'(exp_q.size()), 32'd0);

    // ---- A: reset in the middle of an erase pass ----
    push_rect(51, 49, 3'b000);
    fwdY = 1'b1;
    wait_plot(0, 60, cyc);
    fwdY = 1'b0;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_plot", 32'(plots[0]), 32'd0);
    check("abort_posx", 32'(pxs[0]), 32'd50);
    check("abort_posy", 32'(pys[0]), 32'd50);
    @(negedge clk);
    exp_q.delete();
    push_rect(50, 50, 3'b100);
    rst[0] = 1'b0;
    wait_done(0, 100, cyc);
    repeat (2) @(negedge clk);
    check("abort_redraw_queue", 32'(exp_q.size()), 32'd0);
    rst[0] = 1'b1;

    // ---- instance B: clamp at the right edge ----
    push_rect(154, 50, 3'b100);
    push_rect(154, 50, 3'b000);
    push_rect(156, 50, 3'b100);
    @(negedge clk);
    rst[1] = 1'b0;
    fwdX = 1'b1;
    repeat (140) @(negedge clk);
    fwdX = 1'b0;
    repeat (40) @(negedge clk);
    check("clamp_posx", 32'(pxs[1]), 32'd156);
    check("clamp_done_cnt", 32'(done_cnt[1]), 32'd2);
    check("clamp_queue", 32'(exp_q.size()), 32'd0);
    rst[1] = 1'b1;

    // ---- instance C: ticks during a move collapse into one ----
    push_rect(50, 50, 3'b100);
    push_rect(50, 50, 3'b000);
    push_rect(51, 50, 3'b100);
    push_rect(51, 50, 3'b000);
    push_rect(52, 50, 3'b100);
    push_rect(52, 50, 3'b000);
    push_rect(53, 50, 3'b100);
    @(negedge clk);
    rst[2] = 1'b0;
    fwdX = 1'b1;
    wait_done(2, 60, cyc);
    wait_plot(2, 30, cyc);
    wait_done(2, 100, cyc);
    wait_plot(2, 30, cyc);
    check("restart_gap", 32'(cyc), 32'd2);
    fwdX = 1'b0;
    wait_done(2, 100, cyc);
    repeat (4) @(negedge clk);
    fwdX = 1'b1;
    wait_plot(2, 40, cyc);
    check("collapse_gap", 32'(cyc), 32'd10);
    fwdX = 1'b0;
    wait_done(2, 100, cyc);
    repeat (2) @(negedge clk);
    check("collapse_posx", 32'(pxs[2]), 32'd53);
    check("collapse_done_cnt", 32'(done_cnt[2]), 32'd4);
    check("collapse_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised successor to the single-character 4x4 animator.
- Holds one rectangular sprite of configurable size on the 160x120 VGA framebuffer and moves it by STEP pixels per frame tick, driven by the four direction buttons.
- On each move it erases the old rectangle in background colour, then draws the new one, streaming one pixel per clock to the VGA adapter.
- Adds edge clamping, erase-before-draw, no-redraw-when-idle and a programmable frame rate, none of which the single-character animator has.

Parameters:
- X_SCREEN_PIXELS, 160, screen width.
- Y_SCREEN_PIXELS, 120, screen height.
- SPRITE_W, 4, sprite width in pixels (1..16).
- SPRITE_H, 4, sprite height in pixels (1..16).
- STEP, 1, pixels moved per frame tick per axis (1..8).
- START_X, 50, X position after reset.
- START_Y, 50, Y position after reset.
- SPRITE_COLOUR, 3'b100, colour used for draw passes.
- BG_COLOUR, 3'b000, colour used for erase passes.
- FRAME_CYCLES, 833333, iClock cycles per frame tick (50 MHz / 60).

Ports:
- iClock  in  1  system clock
- iReset  in  1  reset; one clock, reset is synchronous and active-high
- iForwardX  in  1  move +X
- iBackX  in  1  move -X
- iForwardY  in  1  move +Y
- iBackY  in  1  move -Y
- oX  out  8  VGA pixel X
- oY  out  7  VGA pixel Y
- oColour  out  3  VGA pixel colour
- oPlot  out  1  pixel write enable
- oDone  out  1  one-cycle pulse when a draw pass completes
- oPosX  out  8  current sprite top-left X
- oPosY  out  7  current sprite top-left Y

Behaviour:
- Reset (sampled on a rising iClock edge while iReset=1):
  - oX=0, oY=0, oColour=0, oPlot=0, oDone=0.
  - Position is START_X/START_Y; tick counter is FRAME_CYCLES-1; pending flag is cleared; state is INIT.
  - Reset mid-pass aborts the pass immediately: no further oPlot.
- Frame tick: a down-counter reaches 0, then reloads FRAME_CYCLES-1, giving one tick every FRAME_CYCLES cycles. A tick sets the pending flag. Ticks arriving while pending is already set collapse into one; they are never queued.
- Pixel scan:
  - Row-major, X inner. Offset counter runs 0..SPRITE_W*SPRITE_H-1.
  - oX=base+cx, oY=base+cy and oColour are registered in the same cycle oPlot=1.
  - A pass is exactly SPRITE_W*SPRITE_H consecutive oPlot-high cycles.
- States:
  - INIT: draw pass at the current position in SPRITE_COLOUR, then DONE.
  - WAIT: oPlot=0. If pending, clear pending, sample the buttons and compute the next position (rules below). If next==current, stay in WAIT (no erase, no draw, no oDone). Otherwise latch the next position and go to ERASE.
  - ERASE: pass at the old position in BG_COLOUR, then UPDATE.
  - UPDATE: one cycle, oPlot=0; the position register takes the latched next value; go to DRAW.
  - DRAW: pass at the new position in SPRITE_COLOUR, then DONE.
  - DONE: one cycle, oDone=1, oPlot=0, then WAIT.
- Latency: WAIT service cycle t gives the first erase pixel at t+1. Move total = 2*W*H+2 cycles from t+1 to the oDone cycle inclusive.
- Position arithmetic (per axis, independent):
  - Forward and back both asserted: no change on that axis.
  - Forward: min(pos+STEP, SCREEN-SPRITE), computed 9-bit to avoid wrap.
  - Back: pos<STEP gives 0, otherwise pos-STEP.
  - Positions never leave [0, SCREEN-SPRITE]; the sprite is never partly off-screen.
- oPosX/oPosY show the position register, which updates in UPDATE, not at the tick.
- Buttons are sampled only in the WAIT service cycle. Changes during a pass have no effect.

Test Plan:
- Reset, FRAME_CYCLES=20, defaults, no buttons -> 16 oPlot cycles covering (50..53, 50..53) row-major, colour 3'b100; oDone pulses once; after that no oPlot for 200 cycles.
- iForwardX held one tick -> 16 erase pixels at (50..53, 50..53) colour 0, one gap cycle, 16 draw pixels at (51..54, 50..53) colour 3'b100, then oDone; oPosX=51.
- iForwardX and iBackX together with iBackY -> X unchanged, Y moves 50→49; erase at Y 50..53, draw at Y 49..52.
- START_X=154, STEP=4, iForwardX held 3 ticks -> oPosX 156, then no redraw and no oDone on later ticks; oX never exceeds 159.
- FRAME_CYCLES=10 with SPRITE 4x4 (pass pair of 34 cycles > 10) -> multiple ticks during a move collapse: exactly one further move follows DONE.
- iReset asserted mid-ERASE -> oPlot low on the next cycle, position returns to 50/50, and INIT redraws 16 pixels.
